// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB register, load extraction, retire counter.
// Optional MEM-stage forward bus enabled by defining WB_FWD_EN.
module writeback_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        m_valid,
  input  logic        m_reg_write,
  input  logic [4:0]  m_rd,
  input  logic [1:0]  m_wb_sel,
  input  logic [2:0]  m_funct3,
  input  logic [1:0]  m_addr_lo,
  input  logic [31:0] m_alu_result,
  input  logic [31:0] m_mem_rdata,
  input  logic [31:0] m_pc_plus4,
  output logic        en,
  output logic [4:0]  rd,
  output logic [31:0] register_file_data,
  output logic [63:0] instret,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
);

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t         stage_q, stage_d;
  logic [63:0] instret_q, instret_d;

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] next_data;

  always_comb begin
    byte_sel = 8'h00;
    unique case (m_addr_lo)
      2'd0: byte_sel = m_mem_rdata[7:0];
      2'd1: byte_sel = m_mem_rdata[15:8];
      2'd2: byte_sel = m_mem_rdata[23:16];
      2'd3: byte_sel = m_mem_rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = m_addr_lo[1] ? m_mem_rdata[31:16]
                            : m_mem_rdata[15:0];
  end

  // Undefined funct3 encodings return zero rather than garbage.
  always_comb begin
    load_data = 32'h0;
    case (m_funct3)
      3'b000: load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b001: load_data = {{16{half_sel[15]}}, half_sel};
      3'b010: load_data = m_mem_rdata;
      3'b100: load_data = {24'h0, byte_sel};
      3'b101: load_data = {16'h0, half_sel};
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    next_data = 32'h0;
    unique case (1'b1)
      (m_wb_sel == 2'b00): next_data = m_alu_result;
      (m_wb_sel == 2'b01): next_data = load_data;
      (m_wb_sel == 2'b10): next_data = m_pc_plus4;
      (m_wb_sel == 2'b11): next_data = 32'h0;
      default:             next_data = 32'h0;
    endcase
  end

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d.valid = 1'b0;
    end else if (!stall) begin
      stage_d.valid     = m_valid;
      stage_d.reg_write = m_reg_write;
      stage_d.rd        = m_rd;
      stage_d.data      = next_data;
    end
  end

  always_comb begin
    instret_d = instret_q;
    if (m_valid && !stall && !flush)
      instret_d = instret_q + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q   <= '0;
      instret_q <= 64'h0;
    end else begin
      stage_q   <= stage_d;
      instret_q <= instret_d;
    end
  end

  // x0 is hardwired, so a write to it is suppressed here.
  assign en = stage_q.valid & stage_q.reg_write
            & (stage_q.rd != 5'd0);
  assign rd                 = stage_q.rd;
  assign register_file_data = stage_q.data;
  assign instret            = instret_q;

`ifdef WB_FWD_EN
  assign fwd_valid = m_valid & m_reg_write
                   & (m_rd != 5'd0) & ~flush;
  assign fwd_rd    = m_rd;
  assign fwd_data  = next_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = 5'd0;
  assign fwd_data  = 32'h0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage against a behavioural model.
// Randomized plus directed load, stall, flush and reset sequences.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, m_valid, m_reg_write;
  logic [4:0]  m_rd;
  logic [1:0]  m_wb_sel;
  logic [2:0]  m_funct3;
  logic [1:0]  m_addr_lo;
  logic [31:0] m_alu_result, m_mem_rdata, m_pc_plus4;
  logic        en;
  logic [4:0]  rd;
  logic [31:0] register_file_data;
  logic [63:0] instret;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;

  writeback_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_reg_write(m_reg_write), .m_rd(m_rd),
    .m_wb_sel(m_wb_sel), .m_funct3(m_funct3),
    .m_addr_lo(m_addr_lo), .m_alu_result(m_alu_result),
    .m_mem_rdata(m_mem_rdata), .m_pc_plus4(m_pc_plus4),
    .en(en), .rd(rd), .register_file_data(register_file_data),
    .instret(instret), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [63:0] inst;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // model state: what the architecture says the retired entry is
  logic        mv, mrw;
  logic [4:0]  mrd;
  logic [31:0] mdata;
  logic [63:0] minst;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_data(
    logic [1:0] sel, logic [2:0] f3, logic [1:0] a,
    logic [31:0] alu, logic [31:0] w, logic [31:0] pc4);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * int'(a)));
    h = 16'(w >> (16 * int'(a[1])));
    if (sel == 2'd0) return alu;
    if (sel == 2'd2) return pc4;
    if (sel == 2'd3) return 32'h0;
    if (f3 == 3'd0) return 32'($signed(b));
    if (f3 == 3'd4) return 32'(b);
    if (f3 == 3'd1) return 32'($signed(h));
    if (f3 == 3'd5) return 32'(h);
    if (f3 == 3'd2) return w;
    return 32'h0;
  endfunction

  task automatic model_reset();
    mv = 0; mrw = 0; mrd = 0; mdata = 0; minst = 0;
  endtask

  task automatic step(logic st, logic fl, logic v, logic rw,
                      logic [4:0] r, logic [1:0] sel,
                      logic [2:0] f3, logic [1:0] a,
                      logic [31:0] alu, logic [31:0] w,
                      logic [31:0] pc4);
    exp_t e;
    logic [31:0] nd;
    logic fv;
    @(negedge clk);
    stall = st; flush = fl; m_valid = v; m_reg_write = rw;
    m_rd = r; m_wb_sel = sel; m_funct3 = f3; m_addr_lo = a;
    m_alu_result = alu; m_mem_rdata = w; m_pc_plus4 = pc4;
    nd = ref_data(sel, f3, a, alu, w, pc4);
    if (fl) mv = 0;
    else if (!st) begin
      mv = v; mrw = rw; mrd = r; mdata = nd;
    end
    if (v && !st && !fl) minst = minst + 64'd1;
    e.en = mv && mrw && (mrd != 0);
    e.rd = mrd; e.data = mdata; e.inst = minst;
    sb.push_back(e);
    #1;
`ifdef WB_FWD_EN
    fv = v && rw && (r != 0) && !fl;
    chk("fwd_valid", 64'(fwd_valid), 64'(fv));
    if (fv) begin
      chk("fwd_rd", 64'(fwd_rd), 64'(r));
      chk("fwd_data", 64'(fwd_data), 64'(nd));
    end
`else
    fv = 1'b0;
    chk("fwd_tied", {31'h0, fwd_valid, fwd_rd, fwd_data},
        {32'h0, fv, 31'h0});
`endif
  endtask

  task automatic rstep();
    logic [1:0] s;
    s = 2'($urandom_range(0, 3));
    step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
         1'($urandom), $urandom_range(0, 4) != 0,
         5'($urandom_range(0, 7) == 0 ? 0 : $urandom),
         s, 3'($urandom), 2'($urandom),
         $urandom, $urandom, $urandom);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("en", 64'(en), 64'(e.en));
      if (e.en) begin
        chk("rd", 64'(rd), 64'(e.rd));
        chk("data", 64'(register_file_data), 64'(e.data));
      end
      chk("instret", instret, e.inst);
    end
  end

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 0; stall = 0; flush = 0; m_valid = 0;
    m_reg_write = 0; m_rd = 0; m_wb_sel = 0; m_funct3 = 0;
    m_addr_lo = 0; m_alu_result = 0; m_mem_rdata = 0;
    m_pc_plus4 = 0;
    model_reset();
    #1;
    chk("rst_en", 64'(en), 64'h0);
    chk("rst_rd", 64'(rd), 64'h0);
    chk("rst_data", 64'(register_file_data), 64'h0);
    chk("rst_inst", instret, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    step(0, 0, 1, 1, 5'd5, 2'd0, 3'd0, 2'd0,
         32'hDEADBEEF, 32'h0, 32'h0);
    after_edge();
    chk("alu_data", 64'(register_file_data), 64'hDEADBEEF);
    chk("alu_inst", instret, 64'd1);

    step(0, 0, 1, 1, 5'd7, 2'd1, 3'd0, 2'd3, 0, 32'h80F17F00, 0);
    after_edge();
    chk("lb3", 64'(register_file_data), 64'hFFFFFF80);
    step(0, 0, 1, 1, 5'd7, 2'd1, 3'd4, 2'd1, 0, 32'h80F17F00, 0);
    after_edge();
    chk("lbu1", 64'(register_file_data), 64'h0000007F);
    step(0, 0, 1, 1, 5'd7, 2'd1, 3'd1, 2'd2, 0, 32'h80F17F00, 0);
    after_edge();
    chk("lh2", 64'(register_file_data), 64'hFFFF80F1);
    step(0, 0, 1, 1, 5'd7, 2'd1, 3'd5, 2'd0, 0, 32'h80F17F00, 0);
    after_edge();
    chk("lhu0", 64'(register_file_data), 64'h00007F00);

    step(0, 0, 1, 1, 5'd0, 2'd0, 3'd0, 2'd0, 32'h1234, 0, 0);
    after_edge();
    chk("x0_en", 64'(en), 64'h0);
    chk("x0_inst", instret, 64'd6);

    step(0, 0, 1, 1, 5'd9, 2'd2, 3'd0, 2'd0, 0, 0, 32'h400);
    for (int i = 0; i < 3; i++)
      step(1, 0, 1, 1, 5'd3, 2'd0, 3'd0, 2'd0, $urandom, 0, 0);
    step(1, 1, 1, 1, 5'd4, 2'd0, 3'd0, 2'd0, 32'h55, 0, 0);
    after_edge();
    chk("flush_en", 64'(en), 64'h0);
    chk("flush_inst", instret, 64'd7);

    for (int i = 0; i < 300; i++) rstep();

    step(0, 0, 1, 1, 5'd12, 2'd0, 3'd0, 2'd0, 32'hCAFE0001, 0, 0);
    after_edge();
    chk("pre_rst_en", 64'(en), 64'h1);
    rst_n = 0;
    #1;
    chk("arst_en", 64'(en), 64'h0);
    chk("arst_rd", 64'(rd), 64'h0);
    chk("arst_data", 64'(register_file_data), 64'h0);
    chk("arst_inst", instret, 64'h0);
    #1 rst_n = 1;
    model_reset();

    for (int i = 0; i < 200; i++) rstep();
    after_edge();
    chk("sb_drain", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
